ps2_frame_rx: RTL and testbench
===============================

// Module: ps2_frame_rx
// PURPOSE
//  Upstream stage of the keyboard display path: deserialises PS/2 device frames (ps2_clk/ps2_data)
//  into scan-code bytes, checks framing/parity, and buffers them in a small FIFO.
//  The downstream scan-code/ASCII display stage consumes `data` one byte per `rd_en` pop.
//  Break (F0) and extended (E0) prefixes pass through as ordinary bytes; no key decoding here.
// PARAMETERS
//  FIFO_DEPTH   8      entries; power of two, >=2
//  SYNC_STAGES  3      flops on ps2_clk/ps2_data; >=2
//  TIMEOUT_CYC  50000  clk cycles with no ps2_clk falling edge before a partial frame is aborted
// PORTS
//  clk        in   1  system clock (50 MHz nominal)
//  clrn       in   1  reset; one clock, synchronous, active-low
//  ps2_clk    in   1  PS/2 clock from device, asynchronous
//  ps2_data   in   1  PS/2 data from device, asynchronous
//  rd_en      in   1  pop head byte; honoured only while ready=1
//  data       out  8  FIFO head byte (show-ahead); 8'h00 while empty
//  ready      out  1  FIFO non-empty
//  overflow   out  1  sticky: valid frame dropped because FIFO full
//  frame_err  out  1  one-cycle pulse: bad start/stop/parity, or timeout abort
// BEHAVIOUR
//  Reset (clrn=0 at posedge): sync chains to 1, bit count 0, timeout counter 0, pointers 0,
//   ready=0, data=0, overflow=0, frame_err=0. Reset mid-frame discards the partial frame.
//  Edge detect: falling edge when ps2_clk sync chain last two stages == 2'b10 (oldest=1).
//   ps2_data sampled from its own sync chain in that same cycle.
//  Frame = 11 bits LSB-first: start(0), d0..d7, odd parity, stop(1). Shift on each edge.
//  FSM: IDLE -> (edge, sampled bit 0) RECV; a 1 in IDLE is ignored (no error).
//   RECV: count 1..10; on 11th edge -> CHECK. CHECK (one cycle): valid iff stop==1 and
//   ^{d7..d0,parity}==1. Valid & not full -> write; valid & full -> drop, set overflow;
//   invalid -> frame_err pulse. CHECK -> IDLE always.
//  Latency: 11th edge detected at cycle N, CHECK at N+1, ready/data updated from N+2.
//  Timeout: counter clears on every edge, counts only in RECV; at TIMEOUT_CYC -> IDLE,
//   frame_err pulse, bit count cleared.
//  FIFO: pointers log2(FIFO_DEPTH)+1 bits, wrap naturally; full when MSBs differ, low bits equal.
//   Pop with rd_en&ready advances read pointer next cycle. rd_en while empty: no effect.
//   Simultaneous write and pop, incl. when full: pop first-frees, write accepted, no overflow.
//  overflow clears on the first successful pop after being set (not on write).
// STRUCTURE
//  Package ps2_pkg: PS2_FRAME_BITS=11, PS2_BREAK=8'hF0, PS2_EXT=8'hE0, rx state enum
//   {IDLE,RECV,CHECK}, shared with the downstream display stage.
//  Sub-module sync_fifo (parameterised width/depth, show-ahead, full/empty flags).
//  Top holds synchronisers, edge detect, shift register, FSM, timeout counter.
// TESTING
//  Send frame 0x1C (parity 0) -> ready rises 2 cycles after 11th edge, data=8'h1C; pop -> ready=0.
//  Send 0x1C, F0, 1C without popping -> data 1C,F0,1C in order across three pops; overflow=0.
//  Send 0x1C with parity bit flipped -> frame_err one-cycle pulse, ready stays 0.
//  Send 9 valid frames, no pops (depth 8) -> 8 bytes held, overflow=1; first pop clears it.
//  Stop after 5 bits, idle TIMEOUT_CYC cycles -> frame_err pulse; next full frame 0x32 received.
//  Pull clrn low mid-frame then resend 0x45 -> only 0x45 in FIFO, all outputs 0 during reset.

Source files
------------

// File: rtl/ps2_frame_rx_pkg.sv
// Shared PS/2 receive definitions: frame geometry, prefix bytes, receiver state encoding.
// The downstream scan-code display stage imports this package too.
package ps2_pkg;

    localparam int         PS2_FRAME_BITS = 11;
    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK
    } ps2_rx_state_e;

    // Frame is held LSB-first: [0]=start, [8:1]=data, [9]=odd parity, [10]=stop.
    function automatic logic ps2_frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
        return f[PS2_FRAME_BITS-1] && (^f[PS2_FRAME_BITS-2:1]);
    endfunction

endpackage

// File: rtl/ps2_frame_rx_if.sv
// PS/2 receiver bus: device-side serial lines plus the show-ahead byte FIFO read side.
// master = device model / consumer, slave = the receiver.
interface ps2_frame_rx_if;

    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_en;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data, rd_en,
        input  data, ready, overflow, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data, rd_en,
        output data, ready, overflow, frame_err
    );

endinterface

// File: rtl/ps2_frame_rx_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers; head reads as zero while empty.
// A pop in the same cycle frees a slot, so a write to a full FIFO is accepted then.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              rd_fire, wr_fire;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rd_fire = rd_en && !empty;
    assign wr_fire = wr_en && (!full || rd_fire);
    assign rd_data = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q + {{AW{1'b0}}, wr_fire};
        rptr_d = rptr_q + {{AW{1'b0}}, rd_fire};
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the device lines, shifts in 11-bit frames on ps2_clk
// falling edges, validates stop/parity and queues good scan-code bytes in a FIFO.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 50000
) (
    input logic           clk,
    input logic           clrn,
    ps2_frame_rx_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0]    clk_sync_q, dat_sync_q;
    ps2_rx_state_e             state_q;
    logic [3:0]                cnt_q;
    logic [PS2_FRAME_BITS-1:0] shreg_q;
    logic [TW-1:0]             to_q;
    logic                      frame_err_q, overflow_q;
    logic                      fall, bit_in, frame_ok, wr_en, pop, fifo_full, fifo_empty;

    assign fall     = clk_sync_q[SYNC_STAGES-1] && !clk_sync_q[SYNC_STAGES-2];
    assign bit_in   = dat_sync_q[SYNC_STAGES-1];
    assign frame_ok = ps2_frame_ok(shreg_q);
    assign wr_en    = (state_q == CHECK) && frame_ok;
    assign pop      = bus.rd_en && bus.ready;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], bus.ps2_data};
        end
    end

    // Shift new bits in at the top so the start bit ends up in bit 0 after 11 edges.
    always_ff @(posedge clk) begin
        if (fall && (state_q == RECV || (state_q == IDLE && !bit_in)))
            shreg_q <= {bit_in, shreg_q[PS2_FRAME_BITS-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            to_q        <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (fall)                  to_q <= '0;
            else if (state_q == RECV)  to_q <= to_q + TW'(1);
            case (state_q)
                IDLE: begin
                    if (fall && !bit_in) begin
                        cnt_q   <= 4'd1;
                        state_q <= RECV;
                    end
                end
                RECV: begin
                    if (fall) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'(PS2_FRAME_BITS - 1)) state_q <= CHECK;
                    end else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
                        // Device stalled mid-frame: drop the partial frame and report it.
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        to_q        <= '0;
                        frame_err_q <= 1'b1;
                    end
                end
                CHECK: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    frame_err_q <= !frame_ok;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A pop clears the sticky flag; a drop can only happen when no pop frees a slot.
    always_ff @(posedge clk) begin
        if (!clrn)                          overflow_q <= 1'b0;
        else if (pop)                       overflow_q <= 1'b0;
        else if (wr_en && fifo_full)        overflow_q <= 1'b1;
    end

    sync_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .wr_en   (wr_en),
        .wr_data (shreg_q[8:1]),
        .rd_en   (bus.rd_en),
        .rd_data (bus.data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.ready     = !fifo_empty;
    assign bus.overflow  = overflow_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Bench for ps2_frame_rx: table of single frames, hand-written timing/corner sequences,
// and random traffic checked against a queue-based model of the receiver and FIFO.
module tb_ps2_frame_rx;
    import ps2_pkg::*;

    localparam int TO    = 300;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    ps2_frame_rx_if bus ();

    ps2_frame_rx #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (3),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    int tests   = 0;
    int fails   = 0;
    int err_cnt = 0;
    int exp_err = 0;
    logic [7:0] q[$];
    bit ovf = 1'b0;

    always @(negedge clk) if (bus.frame_err === 1'b1) err_cnt++;

    typedef struct {
        logic [7:0] d;
        bit         bp;
        bit         bs;
        bit         exp_rdy;
        logic [7:0] exp_dat;
        int         exp_fe;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input bit bp, input bit bs);
        return {1'b1 ^ bs, (~^d) ^ bp, d, 1'b0};
    endfunction

    task automatic drive_bit(input logic b);
        bus.ps2_data = b;
        repeat (4) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (8) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) drive_bit(f[i]);
    endtask

    task automatic model_frame(input logic [7:0] d, input bit bp, input bit bs);
        if (bp || bs)            exp_err++;
        else if (q.size() < DEPTH) q.push_back(d);
        else                     ovf = 1'b1;
    endtask

    task automatic tx(input logic [7:0] d, input bit bp, input bit bs);
        send(mk(d, bp, bs), 11);
        model_frame(d, bp, bs);
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        if (q.size() > 0) begin
            void'(q.pop_front());
            ovf = 1'b0;
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".ready"}, bus.ready, (q.size() > 0) ? 1 : 0);
        chk({tag, ".data"}, bus.data, (q.size() > 0) ? q[0] : 8'h00);
        chk({tag, ".overflow"}, bus.overflow, ovf);
        chk({tag, ".errs"}, err_cnt, exp_err);
    endtask

    // Sends a frame with the last falling edge placed exactly, sampling around the write cycle.
    task automatic send_timed(input logic [10:0] f, input bit pop_sim,
                              output logic r3, output logic r4, output logic fe4, output logic fe5);
        for (int i = 0; i < 10; i++) drive_bit(f[i]);
        bus.ps2_data = f[10];
        repeat (4) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        r3 = bus.ready;
        if (pop_sim) bus.rd_en = 1'b1;
        @(negedge clk);
        r4  = bus.ready;
        fe4 = bus.frame_err;
        bus.rd_en = 1'b0;
        @(negedge clk);
        fe5 = bus.frame_err;
        repeat (4) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic r3, r4, fe4, fe5;
        int e0;
        logic [7:0] b;

        tbl[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 0};
        tbl[1] = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'h00, 1};
        tbl[2] = '{PS2_BREAK, 1'b0, 1'b0, 1'b1, PS2_BREAK, 0};
        tbl[3] = '{PS2_EXT, 1'b0, 1'b0, 1'b1, PS2_EXT, 0};
        tbl[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 0};
        tbl[5] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 0};
        tbl[6] = '{8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 1};
        tbl[7] = '{8'h80, 1'b1, 1'b0, 1'b0, 8'h00, 1};
        tbl[8] = '{8'hAA, 1'b0, 1'b0, 1'b1, 8'hAA, 0};

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        bus.rd_en    = 1'b0;
        clrn         = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.ready", bus.ready, 0);
        chk("reset.data", bus.data, 0);
        chk("reset.overflow", bus.overflow, 0);
        chk("reset.frame_err", bus.frame_err, 0);
        clrn = 1'b1;
        repeat (2) @(negedge clk);

        // Latency of a good frame, then pop.
        send_timed(mk(8'h1C, 0, 0), 1'b0, r3, r4, fe4, fe5);
        chk("lat.ready_n1", r3, 0);
        chk("lat.ready_n2", r4, 1);
        chk("lat.no_err", fe4, 0);
        chk("lat.data", bus.data, 8'h1C);
        pop();
        chk("lat.popped", bus.ready, 0);

        // Bad parity: one-cycle error pulse, nothing queued.
        send_timed(mk(8'h1C, 1, 0), 1'b0, r3, r4, fe4, fe5);
        chk("par.err_pulse", fe4, 1);
        chk("par.err_one_cycle", fe5, 0);
        chk("par.ready", r4, 0);
        exp_err++;

        // Single-frame table.
        for (int i = 0; i < 9; i++) begin
            e0 = err_cnt;
            send(mk(tbl[i].d, tbl[i].bp, tbl[i].bs), 11);
            chk($sformatf("tbl%0d.ready", i), bus.ready, tbl[i].exp_rdy);
            chk($sformatf("tbl%0d.data", i), bus.data, tbl[i].exp_dat);
            chk($sformatf("tbl%0d.errs", i), err_cnt - e0, tbl[i].exp_fe);
            exp_err += tbl[i].exp_fe;
            if (tbl[i].exp_rdy) begin
                pop();
                chk($sformatf("tbl%0d.popped", i), bus.ready, 0);
            end
        end

        // Pop while empty has no effect.
        pop();
        chk_model("empty_pop");

        // A lone 1 on an edge in IDLE is ignored.
        drive_bit(1'b1);
        chk_model("idle_one");
        tx(8'h5A, 0, 0);
        chk_model("idle_one.next");
        pop();

        // Three frames in order.
        tx(8'h1C, 0, 0);
        tx(PS2_BREAK, 0, 0);
        tx(8'h1C, 0, 0);
        chk_model("three");
        for (int i = 0; i < 3; i++) begin
            pop();
            chk_model($sformatf("three.pop%0d", i));
        end

        // Nine frames into a depth-8 FIFO.
        for (int i = 0; i < 9; i++) tx(8'h10 + 8'(i), 0, 0);
        chk_model("ovf.full");
        chk("ovf.flag", bus.overflow, 1);
        while (q.size() > 0) begin
            pop();
            chk_model("ovf.drain");
        end

        // Write and pop in the same cycle while full.
        for (int i = 0; i < 8; i++) tx(8'h60 + 8'(i), 0, 0);
        send_timed(mk(8'h77, 0, 0), 1'b1, r3, r4, fe4, fe5);
        void'(q.pop_front());
        q.push_back(8'h77);
        chk_model("simul");
        while (q.size() > 0) begin
            pop();
            chk_model("simul.drain");
        end

        // Timeout after a partial frame.
        send(mk(8'hAB, 0, 0), 5);
        repeat (TO - 50) @(negedge clk);
        chk_model("to.before");
        repeat (70) @(negedge clk);
        exp_err++;
        chk_model("to.after");
        tx(8'h32, 0, 0);
        chk_model("to.next");
        pop();

        // Reset mid-frame with a byte already queued.
        tx(8'h11, 0, 0);
        send(mk(8'h99, 0, 0), 5);
        clrn = 1'b0;
        @(negedge clk);
        chk("rst.ready", bus.ready, 0);
        chk("rst.data", bus.data, 0);
        chk("rst.overflow", bus.overflow, 0);
        chk("rst.frame_err", bus.frame_err, 0);
        q.delete();
        ovf  = 1'b0;
        clrn = 1'b1;
        repeat (2) @(negedge clk);
        tx(8'h45, 0, 0);
        chk_model("rst.resend");
        pop();
        chk_model("rst.popped");

        // Random traffic against the model.
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: tx(b, 0, 0);
                6:                tx(b, 1, 0);
                7:                tx(b, 0, 1);
                default:          pop();
            endcase
            chk_model($sformatf("rnd%0d", i));
        end
        while (q.size() > 0) begin
            pop();
            chk_model("rnd.drain");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
